// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the FP compare arbiter slice.
// FloPoCo operand layout (20 bits, MSB first): exn[1:0] | sign | exponent[10:0] | fraction[5:0].
// Exponent bias is 1023; there are no subnormals, specials are carried in exn.
package fp_cmp_pkg;

  localparam int unsigned FP_WE       = 11;
  localparam int unsigned FP_WF       = 6;
  localparam int unsigned FP_W        = FP_WE + FP_WF + 3;
  localparam int unsigned FP_SIGN_POS = FP_WE + FP_WF;
  localparam int unsigned FP_EXN_LO   = FP_SIGN_POS + 1;
  localparam int unsigned FP_EXN_HI   = FP_SIGN_POS + 2;
  localparam int unsigned FP_EXP_MAX  = (1 << FP_WE) - 1;
  localparam int unsigned LAT_DEFAULT = 3;

  typedef enum logic [1:0] {
    EXN_ZERO   = 2'b00,
    EXN_NORMAL = 2'b01,
    EXN_INF    = 2'b10,
    EXN_NAN    = 2'b11
  } exn_t;

  typedef struct packed {
    exn_t             exn;
    logic             sign;
    logic [FP_WE-1:0] exp;
    logic [FP_WF-1:0] frac;
  } fp_t;

endpackage

// File: rtl/FPSub_11_6_F400_uid2.sv
// FloPoCo-compatible FP subtractor R = X - Y (wE=11, wF=6), round to nearest even,
// no subnormals: results below the smallest normal flush to zero, above the largest go to inf.
// The result is computed in one combinational step and delayed through LAT registers.
// Ports: clk; X, Y operands; R result, valid LAT cycles after X/Y were presented.
module FPSub_11_6_F400_uid2
  import fp_cmp_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT
) (
  input  logic            clk,
  input  logic [FP_W-1:0] X,
  input  logic [FP_W-1:0] Y,
  output logic [FP_W-1:0] R
);

  fp_t              op_x, op_y, r_c;
  logic             ys, eff_sub, x_big, sb, rup, ovf;
  logic [FP_WE-1:0] eb, es, d;
  logic [FP_WF-1:0] fb, fs;
  logic [9:0]       bm, sm, aligned, n;
  logic [10:0]      sum;
  logic [7:0]       m;
  int               lz, e;

  logic [LAT-1:0][FP_W-1:0] pipe_q;

  assign op_x = fp_t'(X);
  assign op_y = fp_t'(Y);

  // Add X and -Y: swap by magnitude, align with guard/round/sticky, normalise, round.
  always_comb begin
    ys      = ~op_y.sign;
    eff_sub = op_x.sign ^ ys;
    x_big   = {op_x.exp, op_x.frac} >= {op_y.exp, op_y.frac};
    eb      = x_big ? op_x.exp  : op_y.exp;
    es      = x_big ? op_y.exp  : op_x.exp;
    fb      = x_big ? op_x.frac : op_y.frac;
    fs      = x_big ? op_y.frac : op_x.frac;
    sb      = x_big ? op_x.sign : ys;
    d       = eb - es;
    bm      = {1'b1, fb, 3'b000};
    sm      = {1'b1, fs, 3'b000};
    if (d >= 11'd10) aligned = 10'd1;
    else             aligned = (sm >> d) | {9'd0, |(sm & ~(10'h3FF << d))};
    sum = eff_sub ? ({1'b0, bm} - {1'b0, aligned}) : ({1'b0, bm} + {1'b0, aligned});

    // Highest set bit wins, giving the leading-zero count of sum[9:0].
    lz = 0;
    for (int i = 0; i < 10; i++) begin
      if (sum[i]) lz = 9 - i;
    end

    if (sum[10]) begin
      n = {sum[10:2], sum[1] | sum[0]};
      e = int'(eb) + 1;
    end else begin
      n = sum[9:0] << lz;
      e = int'(eb) - lz;
    end
    rup = n[2] & (n[3] | n[1] | n[0]);
    m   = {1'b0, n[9:3]} + {7'd0, rup};
    ovf = m[7] & ~m[6];
    if (ovf) e = e + 1;

    r_c      = '0;
    r_c.sign = sb;
    if (op_x.exn == EXN_NAN || op_y.exn == EXN_NAN ||
        (op_x.exn == EXN_INF && op_y.exn == EXN_INF && op_x.sign == op_y.sign)) begin
      r_c.exn = EXN_NAN;
    end else if (op_x.exn == EXN_INF) begin
      r_c.exn  = EXN_INF;
      r_c.sign = op_x.sign;
    end else if (op_y.exn == EXN_INF) begin
      r_c.exn  = EXN_INF;
      r_c.sign = ys;
    end else if (op_x.exn == EXN_ZERO && op_y.exn == EXN_ZERO) begin
      r_c.exn  = EXN_ZERO;
      r_c.sign = op_x.sign & ys;
    end else if (op_x.exn == EXN_ZERO) begin
      r_c      = op_y;
      r_c.sign = ys;
    end else if (op_y.exn == EXN_ZERO) begin
      r_c = op_x;
    end else if (sum == 11'd0) begin
      r_c.exn  = EXN_ZERO;
      r_c.sign = 1'b0;
    end else if (e < 0) begin
      r_c.exn = EXN_ZERO;
    end else if (e > int'(FP_EXP_MAX)) begin
      r_c.exn = EXN_INF;
    end else begin
      r_c.exn  = EXN_NORMAL;
      r_c.exp  = FP_WE'(e);
      r_c.frac = ovf ? 6'd0 : m[5:0];
    end
  end

  // Latency pipe; data only, qualification travels in the caller's tag pipe.
  always_ff @(posedge clk) begin
    pipe_q[0] <= r_c;
    for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign R = pipe_q[LAT-1];

endmodule

// File: rtl/fp_less_pipe.sv
// Shared A<B compare pipe: FP subtractor, requester tag pipe and registered less flag.
// A compare issued in cycle t produces its one-hot rsp_valid/rsp_less in cycle t+LAT+1.
// Ports: clk, rst (sync, active-high); iss_valid/iss_idx/iss_a/iss_b issue slot;
//        rsp_valid one-hot response strobe, rsp_less result (0 when no response).
module fp_less_pipe
  import fp_cmp_pkg::*;
#(
  parameter  int unsigned width = 19,
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned LAT   = LAT_DEFAULT,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [IDX_W-1:0] iss_idx,
  input  logic [width:0]   iss_a,
  input  logic [width:0]   iss_b,
  output logic [N_REQ-1:0] rsp_valid,
  output logic             rsp_less
);

  logic [width:0]                r;
  fp_t                           r_f;
  logic                          less_c;
  logic                          unused_r;
  logic [LAT-1:0]                tag_valid_q;
  logic [LAT-1:0][IDX_W-1:0]     tag_idx_q;

  FPSub_11_6_F400_uid2 #(.LAT(LAT)) u_sub (
    .clk (clk),
    .X   (iss_a),
    .Y   (iss_b),
    .R   (r)
  );

  // A<B exactly when A-B is a negative normal; zero, inf and NaN all read as not-less.
  assign r_f      = fp_t'(r);
  assign less_c   = (r_f.exn == EXN_NORMAL) && r_f.sign;
  assign unused_r = ^{r_f.exp, r_f.frac};

  // Tag pipe aligned with the subtractor, final stage registers the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_q <= '0;
      tag_idx_q   <= '0;
      rsp_valid   <= '0;
      rsp_less    <= 1'b0;
    end else begin
      tag_valid_q[0] <= iss_valid;
      tag_idx_q[0]   <= iss_idx;
      for (int i = 1; i < int'(LAT); i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_idx_q[i]   <= tag_idx_q[i-1];
      end
      rsp_valid <= tag_valid_q[LAT-1] ? (N_REQ'(1) << tag_idx_q[LAT-1]) : '0;
      rsp_less  <= tag_valid_q[LAT-1] & less_c;
    end
  end

endmodule

// File: rtl/fp_cmp_arbiter.sv
// Round-robin arbiter sharing one pipelined FP A<B compare among N_REQ requesters.
// Ports: clk, rst (sync, active-high); req_valid/req_a/req_b per requester;
//        req_ready one-hot grant (combinational); rsp_valid/rsp_less response; busy in-flight flags.
// Build option FP_CMP_ARB_STATS_EN adds grant_cnt: one saturating 16-bit grant counter per requester.
module fp_cmp_arbiter
  import fp_cmp_pkg::*;
#(
  parameter int unsigned width = 19,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = LAT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*(width+1)-1:0] req_a,
  input  logic [N_REQ*(width+1)-1:0] req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic                     rsp_less,
  output logic [N_REQ-1:0]         busy
`ifdef FP_CMP_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]      grant_cnt
`endif
);

  localparam int unsigned W     = width + 1;
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW    = IDX_W + 1;

  logic [IDX_W-1:0] rr_ptr, grant_idx;
  logic [CW-1:0]    cand;
  logic [N_REQ-1:0] eligible;
  logic             found, grant;
  logic [W-1:0]     iss_a, iss_b;

  // Round-robin search from rr_ptr over requesters that are valid and idle.
  always_comb begin
    eligible  = req_valid & ~busy;
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
    grant     = found && !rst;
    req_ready = grant ? (N_REQ'(1) << grant_idx) : '0;
  end

  assign iss_a = req_a[grant_idx*W +: W];
  assign iss_b = req_b[grant_idx*W +: W];

  // busy stays high through the response cycle and drops at its closing edge,
  // so a requester can only be re-granted the cycle after its response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      busy   <= '0;
    end else begin
      if (grant) rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      busy <= (busy & ~rsp_valid) | req_ready;
    end
  end

  fp_less_pipe #(.width(width), .N_REQ(N_REQ), .LAT(LAT)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (grant),
    .iss_idx   (grant_idx),
    .iss_a     (iss_a),
    .iss_b     (iss_b),
    .rsp_valid (rsp_valid),
    .rsp_less  (rsp_less)
  );

`ifdef FP_CMP_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] cnt_q;

  // Per-requester grant counters, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (grant && cnt_q[grant_idx] != 16'hFFFF) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + 16'd1;
    end
  end

  assign grant_cnt = cnt_q;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: doc/fp_cmp_arbiter.md
FP_CMP_ARBITER -- requirements
Module: fp_cmp_arbiter

Interface
REQ-001 Parameter width, default 19: MSB index of FloPoCo FP operand (20 bits: exn[width:width-1], sign[width-2], exponent 11, fraction 6).
REQ-002 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-003 Parameter LAT, default 3: pipeline depth of FP subtractor in cycles.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N_REQ  per-requester compare request.
REQ-007 req_a  input  N_REQ*(width+1)  packed operand A per requester.
REQ-008 req_b  input  N_REQ*(width+1)  packed operand B per requester.
REQ-009 req_ready  output  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-010 rsp_valid  output  N_REQ  one-hot response strobe, one cycle.
REQ-011 rsp_less  output  1  A<B result, valid with rsp_valid.
REQ-012 busy  output  N_REQ  requester i has a compare in flight.

Function
REQ-013 Shared resource: one pipelined FP subtractor computing R=A-B; at most one issue per cycle.
REQ-014 Arbitration: round-robin among i with req_valid[i]=1 and busy[i]=0; search starts at rr_ptr.
REQ-015 req_ready is combinational from req_valid, busy, rr_ptr; at most one bit set.
REQ-016 On grant to i: operands i issue to pipe, rr_ptr <= (i+1) mod N_REQ, busy[i] <= 1 next cycle.
REQ-017 No grant cycle: rr_ptr unchanged; pipe slot carries valid=0.
REQ-018 Tag pipe: valid bit plus requester index, depth LAT+1, shifts every cycle, no stall.
REQ-019 Less decode: less = (R[width:width-1]==2'b01) && (R[width-2]==1); zero, inf, NaN results give 0.
REQ-020 Less registered once after subtractor; rsp_valid[i] asserts exactly LAT+1 cycles after grant edge.
REQ-021 Response cycle for i: busy[i] cleared same edge; i eligible for grant in that same cycle's arbitration only from next cycle.
REQ-022 rsp_less = 0 when no rsp_valid bit set.
REQ-023 Back-to-back: distinct requesters granted on consecutive cycles; responses in issue order, one per cycle.
REQ-024 req_valid dropped while busy: no effect on in-flight compare; response still delivered.

Reset
REQ-025 rst=1 at clock edge: rr_ptr=0, busy=0, all tag valids=0, rsp_valid=0, rsp_less=0, req_ready=0.
REQ-026 Reset mid-operation: in-flight compares discarded, no responses emitted for them.
REQ-027 req_ready forced 0 while rst=1.

Configuration
REQ-028 Macro FP_CMP_ARB_STATS_EN defined: adds output grant_cnt N_REQ*16 bits, per-requester grant counters, cleared by rst, saturate at 16'hFFFF.
REQ-029 Macro undefined: no counters, no grant_cnt port; all other behaviour identical.

Structure
REQ-030 Shared package fp_cmp_pkg: FloPoCo field offsets, exn codes (00 zero, 01 normal, 10 inf, 11 NaN), default LAT.
REQ-031 One sub-module fp_less_pipe: wraps FPSub_11_6_F400_uid2 plus tag pipe and less register.
REQ-032 Arbiter, rr_ptr, busy and stats logic in fp_cmp_arbiter top.

Verification
REQ-033 Requester 0, A=0x4FFC0 (1.0), B=0x50000 (2.0) -> rsp_valid=4'b0001, rsp_less=1 at grant+LAT+1.
REQ-034 Requester 2, A=0x50000, B=0x4FFC0; then A=B=0x4FFC0 -> rsp_less=0 both.
REQ-035 All four req_valid held high -> grants 0,1,2,3 on consecutive cycles, then 0 again once busy[0] clears.
REQ-036 Requester 1 holds req_valid after grant -> req_ready[1]=0 until response cycle +1.
REQ-037 rst asserted 1 cycle after grant -> no rsp_valid ever for that compare; busy=0 after reset.
REQ-038 FP_CMP_ARB_STATS_EN build, 5 grants to requester 3 -> grant_cnt[3]=5, others 0.
